// File: rtl/maverickone_reg_scoreboard_pkg.sv
// Shared constants and types for the maverickOne register scoreboard and
// the instruction launcher that consumes its lock vector.
package maverickone_reg_scoreboard_pkg;

  localparam int NUM_REGS        = 32;
  localparam int NUM_OUTSTANDING = 4;
  localparam int NUM_WB_PORTS    = 2;

  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W     = $clog2(NUM_OUTSTANDING + 1);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  locks_t;

endpackage

// File: rtl/maverickone_reg_scoreboard_counter.sv
// One register's pending-write counter. It counts up by at most one and down
// by up to NWB per cycle, clamping at 0 and NOS and flagging either clamp.
module maverickone_reg_scoreboard_counter #(
  parameter int NOS = 4,
  parameter int NWB = 2,
  parameter int CW  = $clog2(NOS + 1),
  parameter int DW  = $clog2(NWB + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          inc_i,
  input  logic [DW-1:0] dec_i,
  output logic          nonzero_o,
  output logic          full_o,
  output logic          underflow_o,
  output logic          overflow_o
);

  // Two extra bits give headroom for both the +1 and the negative range.
  localparam int SW = CW + 2;

  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic signed [SW-1:0] sum;

  // Net update with range check; a flush wipes the count and suppresses flags.
  always_comb begin
    sum         = $signed({2'b00, cnt_q}) + $signed(SW'(inc_i)) - $signed(SW'(dec_i));
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (sum < 0) begin
      cnt_d       = '0;
      underflow_o = 1'b1;
    end else if (sum > $signed(SW'(NOS))) begin
      cnt_d      = CW'(NOS);
      overflow_o = 1'b1;
    end else begin
      cnt_d = sum[CW-1:0];
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nonzero_o = (cnt_q != '0);
  assign full_o    = (cnt_q == CW'(NOS));

endmodule

// File: rtl/maverickone_reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per architectural register and
// presents a lock vector to the launcher. Register 0 is never tracked.
module maverickone_reg_scoreboard
  import maverickone_reg_scoreboard_pkg::*;
#(
  parameter int NR  = NUM_REGS,
  parameter int NOS = NUM_OUTSTANDING,
  parameter int NWB = NUM_WB_PORTS,
  parameter int RIW = $clog2(NR),
  parameter int CW  = $clog2(NOS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               launch_valid_i,
  input  logic               launch_ready_i,
  input  logic               launch_wr_i,
  input  logic [RIW-1:0]     launch_rd_i,
  output logic               launch_allow_o,
  input  logic [NWB-1:0]     wb_valid_i,
  input  logic [NWB*RIW-1:0] wb_rd_i,
  output logic [NR-1:0]      locks_o,
  output logic [CW-1:0]      outstanding_o,
  output logic               err_o
);

  localparam int DW = $clog2(NWB + 1);
  localparam int SW = CW + 2;

  logic          fire;
  logic          fire_ok;
  logic          fire_blocked;
  logic          wb_hit_rd;
  logic [DW-1:0] wb_nz_count;
  logic [NR-1:0] inc;
  logic [DW-1:0] dec [NR];

  logic [NR-1:0] nonzero;
  logic [NR-1:0] full;
  logic [NR-1:0] underflow;
  logic [NR-1:0] overflow;

  logic [CW-1:0]        total_q;
  logic [CW-1:0]        total_d;
  logic signed [SW-1:0] total_sum;
  logic                 total_clamp;
  logic                 err_q;
  logic                 err_d;

  assign fire = launch_valid_i & launch_ready_i & launch_wr_i & (launch_rd_i != '0);

  // Decode writeback ports into per-register decrement counts and spot any
  // writeback that frees a slot on the register currently being launched.
  always_comb begin
    wb_hit_rd   = 1'b0;
    wb_nz_count = '0;
    for (int r = 0; r < NR; r++) begin
      dec[r] = '0;
    end
    for (int k = 0; k < NWB; k++) begin
      if (wb_valid_i[k] && (wb_rd_i[k*RIW +: RIW] != '0)) begin
        wb_nz_count = wb_nz_count + DW'(1);
        if (wb_rd_i[k*RIW +: RIW] == launch_rd_i) begin
          wb_hit_rd = 1'b1;
        end
        for (int r = 1; r < NR; r++) begin
          if (wb_rd_i[k*RIW +: RIW] == RIW'(r)) begin
            dec[r] = dec[r] + DW'(1);
          end
        end
      end
    end
  end

  assign launch_allow_o = ~full[launch_rd_i] | wb_hit_rd;
  assign fire_ok        = fire & launch_allow_o;
  assign fire_blocked   = fire & ~launch_allow_o;

  // One-hot increment for the accepted launch destination.
  always_comb begin
    inc = '0;
    if (fire_ok) begin
      inc[launch_rd_i] = 1'b1;
    end
  end

  assign nonzero[0]   = 1'b0;
  assign full[0]      = 1'b0;
  assign underflow[0] = 1'b0;
  assign overflow[0]  = 1'b0;

  for (genvar r = 1; r < NR; r++) begin : g_cnt
    maverickone_reg_scoreboard_counter #(
      .NOS (NOS),
      .NWB (NWB),
      .CW  (CW),
      .DW  (DW)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .inc_i       (inc[r]),
      .dec_i       (dec[r]),
      .nonzero_o   (nonzero[r]),
      .full_o      (full[r]),
      .underflow_o (underflow[r]),
      .overflow_o  (overflow[r])
    );
  end

  // Total in-flight count, clamped to 0..NOS; flush drops it to zero.
  always_comb begin
    total_sum   = $signed({2'b00, total_q}) + $signed(SW'(fire_ok)) - $signed(SW'(wb_nz_count));
    total_d     = total_q;
    total_clamp = 1'b0;
    if (clear_i) begin
      total_d = '0;
    end else if (total_sum < 0) begin
      total_d     = '0;
      total_clamp = 1'b1;
    end else if (total_sum > $signed(SW'(NOS))) begin
      total_d     = CW'(NOS);
      total_clamp = 1'b1;
    end else begin
      total_d = total_sum[CW-1:0];
    end
  end

  // Sticky error: any clamp or blocked launch; flushed-cycle events are ignored.
  always_comb begin
    err_d = err_q | (~clear_i & ((|underflow) | (|overflow) | total_clamp | fire_blocked));
  end

  // Total and error state registers; only reset clears the error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  assign locks_o       = nonzero;
  assign outstanding_o = total_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_maverickone_reg_scoreboard.sv
// Directed scoreboard bench: each stimulus cycle queues the hand-computed
// post-edge state, and an independent monitor pops and compares it.
module tb_maverickone_reg_scoreboard;

  logic        clk;
  logic        rst_i;
  logic        clear_i;
  logic        launch_valid_i;
  logic        launch_ready_i;
  logic        launch_wr_i;
  logic [4:0]  launch_rd_i;
  logic        launch_allow_o;
  logic [1:0]  wb_valid_i;
  logic [9:0]  wb_rd_i;
  logic [31:0] locks_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  typedef struct {
    logic [31:0] locks;
    logic [2:0]  outs;
    logic        err;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   failCount = 0;

  maverickone_reg_scoreboard dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .launch_valid_i (launch_valid_i),
    .launch_ready_i (launch_ready_i),
    .launch_wr_i    (launch_wr_i),
    .launch_rd_i    (launch_rd_i),
    .launch_allow_o (launch_allow_o),
    .wb_valid_i     (wb_valid_i),
    .wb_rd_i        (wb_rd_i),
    .locks_o        (locks_o),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational allow, queue the
  // expected registered state after the coming edge.
  task automatic applyStimulus(input logic fireV, input logic [4:0] rd,
                               input logic [1:0] wbv, input logic [4:0] w0, input logic [4:0] w1,
                               input logic clr, input logic [31:0] expLocks, input logic [2:0] expOuts,
                               input logic expErr, input logic expAllow, input string name);
    exp_t e;
    @(negedge clk);
    launch_valid_i = fireV;
    launch_ready_i = fireV;
    launch_wr_i    = fireV;
    launch_rd_i    = rd;
    wb_valid_i     = wbv;
    wb_rd_i        = {w1, w0};
    clear_i        = clr;
    #1;
    checkOutput({name, "_allow"}, 32'(launch_allow_o), 32'(expAllow));
    e.locks = expLocks;
    e.outs  = expOuts;
    e.err   = expErr;
    e.name  = name;
    expQ.push_back(e);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) begin
      launch_valid_i = 1'($urandom);
      launch_ready_i = 1'($urandom);
      launch_wr_i    = 1'($urandom);
      launch_rd_i    = 5'($urandom);
      wb_valid_i     = 2'($urandom);
      wb_rd_i        = 10'($urandom);
      clear_i        = 1'($urandom);
      @(negedge clk);
    end
    rst_i          = 1'b0;
    launch_valid_i = 1'b0;
    launch_ready_i = 1'b0;
    launch_wr_i    = 1'b0;
    launch_rd_i    = '0;
    wb_valid_i     = '0;
    wb_rd_i        = '0;
    clear_i        = 1'b0;
    #1;
    checkOutput("reset_locks", locks_o, 32'h0);
    checkOutput("reset_outstanding", 32'(outstanding_o), 32'd0);
    checkOutput("reset_err", 32'(err_o), 32'd0);
    checkOutput("reset_allow", 32'(launch_allow_o), 32'd1);
  endtask

  // Monitor: every cycle with a pending expectation, compare after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.name, "_locks"}, locks_o, e.locks);
        checkOutput({e.name, "_outstanding"}, 32'(outstanding_o), 32'(e.outs));
        checkOutput({e.name, "_err"}, 32'(err_o), 32'(e.err));
      end
    end
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0;
    launch_valid_i = 1'b0; launch_ready_i = 1'b0; launch_wr_i = 1'b0; launch_rd_i = '0;
    wb_valid_i = '0; wb_rd_i = '0;

    resetDut();

    // Single write: fire r5, retire it three cycles later.
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b1, "idle0");
    applyStimulus(1'b1, 5'd5, 2'b00, 5'd0, 5'd0, 1'b0, 32'h20,  3'd1, 1'b0, 1'b1, "fire5");
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 32'h20,  3'd1, 1'b0, 1'b1, "hold5a");
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 32'h20,  3'd1, 1'b0, 1'b1, "hold5b");
    applyStimulus(1'b0, 5'd0, 2'b01, 5'd5, 5'd0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b1, "wb5");

    // Stacked writes to r7, simultaneous fire+wb, dual-port retire.
    applyStimulus(1'b1, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, 32'h80,  3'd1, 1'b0, 1'b1, "fire7a");
    applyStimulus(1'b1, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, 32'h80,  3'd2, 1'b0, 1'b1, "fire7b");
    applyStimulus(1'b1, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, 32'h80,  3'd3, 1'b0, 1'b1, "fire7c");
    applyStimulus(1'b1, 5'd7, 2'b10, 5'd0, 5'd7, 1'b0, 32'h80,  3'd3, 1'b0, 1'b1, "fire_wb7");
    applyStimulus(1'b0, 5'd0, 2'b11, 5'd7, 5'd7, 1'b0, 32'h80,  3'd1, 1'b0, 1'b1, "wb7x2");
    applyStimulus(1'b0, 5'd0, 2'b01, 5'd7, 5'd0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b1, "wb7last");

    // Saturation on r9.
    applyStimulus(1'b1, 5'd9, 2'b00, 5'd0, 5'd0, 1'b0, 32'h200, 3'd1, 1'b0, 1'b1, "fire9a");
    applyStimulus(1'b1, 5'd9, 2'b00, 5'd0, 5'd0, 1'b0, 32'h200, 3'd2, 1'b0, 1'b1, "fire9b");
    applyStimulus(1'b1, 5'd9, 2'b00, 5'd0, 5'd0, 1'b0, 32'h200, 3'd3, 1'b0, 1'b1, "fire9c");
    applyStimulus(1'b1, 5'd9, 2'b00, 5'd0, 5'd0, 1'b0, 32'h200, 3'd4, 1'b0, 1'b1, "fire9d");
    applyStimulus(1'b1, 5'd9, 2'b01, 5'd9, 5'd0, 1'b0, 32'h200, 3'd4, 1'b0, 1'b1, "full9_wb");
    applyStimulus(1'b1, 5'd9, 2'b00, 5'd0, 5'd0, 1'b0, 32'h200, 3'd4, 1'b1, 1'b0, "full9_drop");
    applyStimulus(1'b0, 5'd0, 2'b11, 5'd9, 5'd9, 1'b0, 32'h200, 3'd2, 1'b1, 1'b1, "drain9a");
    applyStimulus(1'b0, 5'd0, 2'b11, 5'd9, 5'd9, 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, "drain9b");

    resetDut();

    // Register 0 is ignored on both sides; underflow on r3 is sticky.
    applyStimulus(1'b1, 5'd0, 2'b10, 5'd0, 5'd0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b1, "r0");
    applyStimulus(1'b0, 5'd0, 2'b01, 5'd3, 5'd0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, "under3");
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, "sticky");

    // Flush with a concurrent launch.
    applyStimulus(1'b1, 5'd2, 2'b00, 5'd0, 5'd0, 1'b0, 32'h4,   3'd1, 1'b1, 1'b1, "fire2");
    applyStimulus(1'b1, 5'd4, 2'b00, 5'd0, 5'd0, 1'b0, 32'h14,  3'd2, 1'b1, 1'b1, "fire4");
    applyStimulus(1'b1, 5'd6, 2'b00, 5'd0, 5'd0, 1'b0, 32'h54,  3'd3, 1'b1, 1'b1, "fire6");
    applyStimulus(1'b1, 5'd8, 2'b00, 5'd0, 5'd0, 1'b1, 32'h0,   3'd0, 1'b1, 1'b1, "clear");
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, "post_clear");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
